token_repeat_arbiter: RTL and testbench

TOKEN_REPEAT_ARBITER -- requirements
Module: token_repeat_arbiter

---
 rtl/token_repeat_arbiter_if.sv | 12 +
 rtl/token_repeat_arbiter.sv | 71 +++++++
 tb/tb_token_repeat_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/token_repeat_arbiter_if.sv
// token_repeat_arbiter_if: lane arrivals, grant enable and shared token output bundle
interface token_repeat_arbiter_if #(parameter int N_LANES = 4);
  localparam int LW = $clog2(N_LANES);
  logic [N_LANES-1:0] a;
  logic               en;
  logic               b;
  logic [LW-1:0]      b_lane;
  logic [N_LANES-1:0] overflow;
  logic               idle;
  modport master (output a, en, input b, b_lane, overflow, idle);
  modport slave (input a, en, output b, b_lane, overflow, idle);
endinterface

// File: rtl/token_repeat_arbiter.sv
// token_repeat_arbiter: round-robin merge of serial lanes, MULT output tokens per incoming '1'
module token_repeat_arbiter #(
  parameter int N_LANES  = 4,
  parameter int MULT     = 2,
  parameter int MAX_PEND = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  token_repeat_arbiter_if.slave bus
);
  localparam int LW = $clog2(N_LANES);
  localparam int PW = $clog2(MAX_PEND + MULT + 1);
  logic [PW-1:0]      pending_q [N_LANES];
  logic [PW-1:0]      pending_d [N_LANES];
  logic [PW-1:0]      pend_eff  [N_LANES];
  logic [N_LANES-1:0] elig, ovf_hit, overflow_q, overflow_d;
  logic [LW-1:0]      ptr_q, ptr_d, b_lane_q, b_lane_d, g, sel;
  logic               b_q, b_d, found, idle_c;
  // per-lane count including this cycle's arrival, overflow detection, eligibility, idle
  always_comb begin
    idle_c = 1'b1;
    for (int i = 0; i < N_LANES; i++) begin
      pend_eff[i] = overflow_q[i] ? '0 : pending_q[i] + (bus.a[i] ? PW'(MULT) : PW'(0));
      ovf_hit[i]  = pend_eff[i] > PW'(MAX_PEND);
      elig[i]     = bus.en && (pend_eff[i] != '0) && !ovf_hit[i];
      if (pending_q[i] != '0) idle_c = 1'b0;
    end
  end
  // round-robin search upward from ptr; scanning offsets downward lets the nearest lane win
  always_comb begin
    found = 1'b0;
    g     = '0;
    sel   = '0;
    for (int j = N_LANES - 1; j >= 0; j--) begin
      sel = LW'((int'(ptr_q) + j) % N_LANES);
      if (elig[sel]) begin
        found = 1'b1;
        g     = sel;
      end
    end
  end
  // next state: grant outputs, pointer advance, counter updates, sticky overflow
  always_comb begin
    b_d        = found;
    b_lane_d   = found ? g : '0;
    ptr_d      = found ? ((int'(g) == N_LANES - 1) ? '0 : g + 1'b1) : ptr_q;
    overflow_d = overflow_q | ovf_hit;
    for (int i = 0; i < N_LANES; i++)
      pending_d[i] = ovf_hit[i] ? '0 : (found && g == LW'(i)) ? pend_eff[i] - 1'b1 : pend_eff[i];
  end
  // state registers; reset discards all pending tokens and flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_LANES; i++) pending_q[i] <= '0;
      ptr_q      <= '0;
      b_q        <= 1'b0;
      b_lane_q   <= '0;
      overflow_q <= '0;
    end else begin
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      b_q        <= b_d;
      b_lane_q   <= b_lane_d;
      overflow_q <= overflow_d;
    end
  end
  assign bus.b        = b_q;
  assign bus.b_lane   = b_lane_q;
  assign bus.overflow = overflow_q;
  assign bus.idle     = idle_c;
endmodule

// File: tb/tb_token_repeat_arbiter.sv
// tb_token_repeat_arbiter: directed checks of token repetition, round-robin, overflow and reset
module tb_token_repeat_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  token_repeat_arbiter_if #(.N_LANES(4)) bus ();
  token_repeat_arbiter #(.N_LANES(4), .MULT(2), .MAX_PEND(200)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic [3:0] av, input logic ev);
    bus.a  = av;
    bus.en = ev;
    @(posedge clk);
    #1;
  endtask
  task automatic out(input string tag, input logic eb, input logic [1:0] el, input logic [3:0] eo);
    chk({tag, " b"}, 32'(bus.b), 32'(eb));
    chk({tag, " b_lane"}, 32'(bus.b_lane), 32'(el));
    chk({tag, " overflow"}, 32'(bus.overflow), 32'(eo));
  endtask
  initial begin
    bus.a  = '0;
    bus.en = 1'b1;
    tick(4'b1111, 1'b1);
    tick(4'b0000, 1'b1);
    out("reset", 1'b0, 2'd0, 4'h0);
    chk("reset idle", 32'(bus.idle), 32'd1);
    rst = 1'b1;
    tick(4'b0001, 1'b1);
    out("single c2", 1'b1, 2'd0, 4'h0);
    chk("single c2 idle", 32'(bus.idle), 32'd0);
    tick(4'b0000, 1'b1);
    out("single c3", 1'b1, 2'd0, 4'h0);
    tick(4'b0000, 1'b1);
    out("single c4", 1'b0, 2'd0, 4'h0);
    chk("single c4 idle", 32'(bus.idle), 32'd1);
    rst = 1'b0;
    tick(4'b0000, 1'b1);
    rst = 1'b1;
    tick(4'b0011, 1'b1);
    out("rr c2", 1'b1, 2'd0, 4'h0);
    tick(4'b0000, 1'b1);
    out("rr c3", 1'b1, 2'd1, 4'h0);
    tick(4'b0000, 1'b1);
    out("rr c4", 1'b1, 2'd0, 4'h0);
    tick(4'b0000, 1'b1);
    out("rr c5", 1'b1, 2'd1, 4'h0);
    tick(4'b0000, 1'b1);
    out("rr c6", 1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 100; i++) begin
      tick(4'b0100, 1'b1);
      out("hold2 on", 1'b1, 2'd2, 4'h0);
    end
    for (int i = 0; i < 100; i++) begin
      tick(4'b0000, 1'b1);
      out("hold2 drain", 1'b1, 2'd2, 4'h0);
    end
    tick(4'b0000, 1'b1);
    out("hold2 end", 1'b0, 2'd0, 4'h0);
    chk("hold2 end idle", 32'(bus.idle), 32'd1);
    for (int i = 1; i <= 250; i++) begin
      tick(4'b1000, 1'b1);
      if (i < 200) out("ovf run", 1'b1, 2'd3, 4'h0);
      else out("ovf hit", 1'b0, 2'd0, 4'h8);
      if (i == 200) chk("ovf idle", 32'(bus.idle), 32'd1);
    end
    tick(4'b1001, 1'b1);
    out("iso c2", 1'b1, 2'd0, 4'h8);
    tick(4'b0000, 1'b1);
    out("iso c3", 1'b1, 2'd0, 4'h8);
    tick(4'b0000, 1'b1);
    out("iso c4", 1'b0, 2'd0, 4'h8);
    tick(4'b0010, 1'b0);
    out("en0", 1'b0, 2'd0, 4'h8);
    tick(4'b0000, 1'b0);
    out("en0", 1'b0, 2'd0, 4'h8);
    tick(4'b0010, 1'b0);
    out("en0", 1'b0, 2'd0, 4'h8);
    tick(4'b0000, 1'b0);
    out("en0", 1'b0, 2'd0, 4'h8);
    tick(4'b0010, 1'b0);
    out("en0", 1'b0, 2'd0, 4'h8);
    tick(4'b0000, 1'b0);
    out("en0", 1'b0, 2'd0, 4'h8);
    chk("en0 idle", 32'(bus.idle), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(4'b0000, 1'b1);
      out("en1 drain", 1'b1, 2'd1, 4'h8);
    end
    tick(4'b0000, 1'b1);
    out("en1 end", 1'b0, 2'd0, 4'h8);
    chk("en1 end idle", 32'(bus.idle), 32'd1);
    tick(4'b0011, 1'b1);
    out("mid burst", 1'b1, 2'd0, 4'h8);
    chk("mid burst idle", 32'(bus.idle), 32'd0);
    rst = 1'b0;
    tick(4'b1111, 1'b1);
    out("mid reset", 1'b0, 2'd0, 4'h0);
    chk("mid reset idle", 32'(bus.idle), 32'd1);
    rst = 1'b1;
    tick(4'b0011, 1'b1);
    out("ptr0 c2", 1'b1, 2'd0, 4'h0);
    tick(4'b0000, 1'b1);
    out("ptr0 c3", 1'b1, 2'd1, 4'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
